// File: rtl/sram_rw_template.sv
// Single-port SRAM array with per-segment write mask, valid/ready request port,
// 1- or 2-cycle read latency and a zero-fill sweep that runs after every reset.
module sram_rw_template #(
    parameter int DEPTH      = 256,
    parameter int SEG_W      = 34,
    parameter int SEGS       = 10,
    parameter int LATENCY    = 1,
    parameter int HOLD_RDATA = 1,
    parameter int INIT_ZERO  = 1,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int DATA_W    = SEG_W * SEGS
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wmode,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [SEGS-1:0]   req_wmask,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              init_done
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                ready_q;
    logic                sweep_we_s;
    logic                rd_fire_s;
    logic                wr_fire_s;
    logic [DATA_W-1:0]   rd_word_s;
    logic                out_valid_s;
    logic [DATA_W-1:0]   out_data_s;
    logic                resp_valid_q;
    logic [DATA_W-1:0]   resp_rdata_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    assign rd_fire_s = req_valid & ready_q & ~req_wmode;
    assign wr_fire_s = req_valid & ready_q & req_wmode;
    assign rd_word_s = mem_q[req_addr];

    // Next-state logic for the init sweep / idle FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sweep_we_s = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (INIT_ZERO != 0) begin
                    sweep_we_s = 1'b1;
                    cnt_d      = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_INIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // FSM state, sweep counter and the ready/init_done flag.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
            cnt_q   <= {ADDR_W{1'b0}};
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == ST_IDLE);
        end
    end

    // Storage array; a reset edge leaves it untouched, so both write sources are gated.
    always_ff @(posedge clock) begin
        if (reset_n && sweep_we_s) begin
            mem_q[cnt_q] <= {DATA_W{1'b0}};
        end else if (reset_n && wr_fire_s) begin
            for (int i = 0; i < SEGS; i++) begin
                if (req_wmask[i]) begin
                    mem_q[req_addr][i*SEG_W +: SEG_W] <= req_wdata[i*SEG_W +: SEG_W];
                end
            end
        end
    end

    // Read data is captured at the accept edge, so later writes cannot disturb it.
    generate
        if (LATENCY == 2) begin : g_lat2
            logic              pipe_valid_q;
            logic [DATA_W-1:0] pipe_data_q;

            // Extra read stage for the two-cycle latency build.
            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    pipe_valid_q <= 1'b0;
                    pipe_data_q  <= {DATA_W{1'b0}};
                end else begin
                    pipe_valid_q <= rd_fire_s;
                    pipe_data_q  <= rd_word_s;
                end
            end

            assign out_valid_s = pipe_valid_q;
            assign out_data_s  = pipe_data_q;
        end else begin : g_lat1
            assign out_valid_s = rd_fire_s;
            assign out_data_s  = rd_word_s;
        end
    endgenerate

    // Response register: pulse valid per read, hold or clear data in between.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= {DATA_W{1'b0}};
        end else begin
            resp_valid_q <= out_valid_s;
            if (out_valid_s) begin
                resp_rdata_q <= out_data_s;
            end else begin
                resp_rdata_q <= (HOLD_RDATA != 0) ? resp_rdata_q : {DATA_W{1'b0}};
            end
        end
    end

    assign req_ready  = ready_q;
    assign init_done  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_sram_rw_template.sv
// Drives two array builds (latency 1 / hold, latency 2 / no hold) with the same
// request stream and checks both against one transaction-level memory model.
module tb_sram_rw_template;

    localparam int DEPTH  = 256;
    localparam int SEG_W  = 34;
    localparam int SEGS   = 10;
    localparam int DATA_W = SEG_W * SEGS;
    localparam int ADDR_W = 8;

    typedef logic [DATA_W-1:0] word_t;
    typedef struct {
        int    due;
        word_t data;
    } rsp_t;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              req_valid;
    logic              req_wmode;
    logic [ADDR_W-1:0] req_addr;
    logic [SEGS-1:0]   req_wmask;
    word_t             req_wdata;
    logic              req_ready_a, resp_valid_a, init_done_a;
    logic              req_ready_b, resp_valid_b, init_done_b;
    word_t             resp_rdata_a, resp_rdata_b;

    always #5 clock = ~clock;

    sram_rw_template #(.LATENCY(1), .HOLD_RDATA(1)) u_dut_a (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready_a),
        .req_wmode(req_wmode), .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
        .resp_valid(resp_valid_a), .resp_rdata(resp_rdata_a), .init_done(init_done_a)
    );

    sram_rw_template #(.LATENCY(2), .HOLD_RDATA(0)) u_dut_b (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready_b),
        .req_wmode(req_wmode), .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
        .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b), .init_done(init_done_b)
    );

    // Behavioural model: memory contents plus queues of responses due at a given edge.
    word_t m [DEPTH];
    rsp_t  qa[$];
    rsp_t  qb[$];
    int    ec = 0;
    int    since = 0;
    bit    exp_ready = 1'b0;
    bit    eva = 1'b0, evb = 1'b0;
    word_t era = '0, erb = '0, last_a = '0;
    bit    chk_en = 1'b0;
    int    n_chk = 0;
    int    n_fail = 0;

    task automatic chk(input string name, input word_t act, input word_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic word_t rnd_word();
        logic [351:0] t;
        for (int k = 0; k < 11; k++) t[k*32 +: 32] = $urandom;
        return t[DATA_W-1:0];
    endfunction

    task automatic model_edge();
        bit   fire;
        rsp_t r;
        ec++;
        if (!reset_n) begin
            since = 0; exp_ready = 1'b0;
            qa.delete(); qb.delete();
            last_a = '0; eva = 1'b0; evb = 1'b0; era = '0; erb = '0;
            return;
        end
        fire = req_valid && exp_ready;
        if (fire && !req_wmode) begin
            r.data = m[req_addr];
            r.due = ec;     qa.push_back(r);
            r.due = ec + 1; qb.push_back(r);
        end
        if (fire && req_wmode) begin
            for (int i = 0; i < SEGS; i++)
                if (req_wmask[i]) m[req_addr][i*SEG_W +: SEG_W] = req_wdata[i*SEG_W +: SEG_W];
        end
        since++;
        if (!exp_ready && since >= DEPTH) begin
            exp_ready = 1'b1;
            foreach (m[k]) m[k] = '0;
        end
        eva = 1'b0; era = last_a;
        if (qa.size() > 0 && qa[0].due == ec) begin
            eva = 1'b1; era = qa[0].data; last_a = era;
            void'(qa.pop_front());
        end
        evb = 1'b0; erb = '0;
        if (qb.size() > 0 && qb[0].due == ec) begin
            evb = 1'b1; erb = qb[0].data;
            void'(qb.pop_front());
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        model_edge();
        chk_en = 1'b1;
        #1;
    endtask

    task automatic issue(input bit wm, input logic [ADDR_W-1:0] a, input logic [SEGS-1:0] mk,
                         input word_t d);
        req_valid = 1'b1; req_wmode = wm; req_addr = a; req_wmask = mk; req_wdata = d;
        cyc();
        req_valid = 1'b0; req_wmode = 1'b0;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input word_t exp, input string name);
        issue(1'b0, a, '0, '0);
        chk({name, "_valid"}, resp_valid_a, 1);
        chk(name, resp_rdata_a, exp);
    endtask

    // Every-cycle comparison of both builds against the model.
    initial forever begin
        @(negedge clock);
        if (chk_en) begin
            chk("ready_a", req_ready_a, exp_ready);
            chk("ready_b", req_ready_b, exp_ready);
            chk("init_done_a", init_done_a, exp_ready);
            chk("init_done_b", init_done_b, exp_ready);
            chk("resp_valid_a", resp_valid_a, eva);
            chk("resp_valid_b", resp_valid_b, evb);
            chk("resp_rdata_a", resp_rdata_a, era);
            chk("resp_rdata_b", resp_rdata_b, erb);
        end
    end

    initial begin
        int    n;
        word_t t2, w1, w2, w3, wa, wb;
        reset_n = 1'b0; req_valid = 1'b0; req_wmode = 1'b0;
        req_addr = '0; req_wmask = '0; req_wdata = '0;
        repeat (3) cyc();
        reset_n = 1'b1;

        n = 0;
        while (!req_ready_a && n < 400) begin cyc(); n++; end
        chk("init_cycles", n, 256);
        chk("init_done_after_sweep", init_done_a, 1);
        rd(8'h00, '0, "t1_rd00");
        rd(8'hFF, '0, "t1_rdff");

        issue(1'b1, 8'h12, 10'h3FF, '1);
        issue(1'b1, 8'h12, 10'h001, '0);
        t2 = '1;
        t2[33:0] = 34'h0;
        rd(8'h12, t2, "t2_masked");

        w1 = rnd_word(); w2 = rnd_word(); w3 = rnd_word();
        issue(1'b1, 8'h01, 10'h3FF, w1);
        issue(1'b1, 8'h02, 10'h3FF, w2);
        issue(1'b1, 8'h03, 10'h3FF, w3);
        req_valid = 1'b1; req_wmode = 1'b0;
        req_addr = 8'h01; cyc();
        chk("t3_a_first", resp_rdata_a, w1);
        req_addr = 8'h02; cyc();
        chk("t3_b_first", resp_rdata_b, w1);
        req_addr = 8'h03; cyc();
        chk("t3_b_second", resp_rdata_b, w2);
        req_valid = 1'b0;
        cyc();
        chk("t3_b_third", resp_rdata_b, w3);

        rd(8'h12, t2, "t4_read");
        repeat (10) cyc();
        chk("t4_hold_a", resp_rdata_a, t2);
        chk("t4_hold_a_valid", resp_valid_a, 0);
        chk("t4_zero_b", resp_rdata_b, 0);

        wa = rnd_word(); wb = rnd_word();
        issue(1'b1, 8'h05, 10'h3FF, wa);
        rd(8'h05, wa, "t5_read_a");
        issue(1'b1, 8'h05, 10'h3FF, wb);
        chk("t5_b_valid", resp_valid_b, 1);
        chk("t5_b_old", resp_rdata_b, wa);
        rd(8'h05, wb, "t5_read_new");

        for (int c = 0; c < 3000; c++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_wmode = $urandom_range(0, 1);
            req_addr  = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 15));
            req_wmask = SEGS'($urandom);
            req_wdata = rnd_word();
            cyc();
        end
        req_valid = 1'b0;
        cyc();

        issue(1'b0, 8'h03, '0, '0);
        reset_n = 1'b0;
        cyc();
        chk("t6_dropped_b", resp_valid_b, 0);
        chk("t6_init_done_low", init_done_a, 0);
        reset_n = 1'b1;
        req_valid = 1'b1; req_wmode = 1'b1; req_addr = 8'h20; req_wmask = 10'h3FF; req_wdata = '1;
        repeat (100) cyc();
        chk("t6_not_ready_mid", req_ready_a, 0);
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1; req_valid = 1'b0;
        n = 0;
        while (!req_ready_a && n < 400) begin cyc(); n++; end
        chk("t6_restart_cycles", n, 256);
        rd(8'h12, '0, "t6_zeroed_12");
        rd(8'h20, '0, "t6_blocked_20");
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
